// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 frame constants, parity helper and mouse packet type.
package ps2_pkg;

    localparam int   PS2_FRAME_BITS = 11;
    localparam logic PS2_START_VAL  = 1'b0;
    localparam logic PS2_STOP_VAL   = 1'b1;
    localparam int   PS2_SYNC_BIT   = 3;

    typedef struct packed {
        logic [7:0] byte2;
        logic [7:0] byte1;
        logic [7:0] byte0;
    } ps2_packet_t;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: deserializes one PS/2 device-to-host frame, flags verdict on the stop edge.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FRAME_BITS = PS2_FRAME_BITS
) (
    input  logic       ps2_clk,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] byte_data,
    output logic       byte_done,
    output logic       byte_err
);

    localparam int BW = $clog2(FRAME_BITS);
    localparam int SW = FRAME_BITS - 2;

    logic [BW-1:0] bit_q, bit_d;
    logic [SW-1:0] sh_q, sh_d;
    logic          stop;

    always_comb begin
        stop      = bit_q == BW'(FRAME_BITS - 1);
        bit_d     = stop ? '0 : (bit_q == '0) ? ((data_in == PS2_START_VAL) ? BW'(1) : '0) : bit_q + 1'b1;
        // Data LSB-first then parity land in sh_q[7:0] and sh_q[SW-1].
        sh_d      = (bit_q != '0 && !stop) ? {data_in, sh_q[SW-1:1]} : sh_q;
        byte_done = stop;
        byte_data = sh_q[7:0];
        byte_err  = !(odd_parity_ok(sh_q[7:0], sh_q[SW-1]) && data_in == PS2_STOP_VAL);
    end

    always_ff @(negedge ps2_clk or posedge reset) begin
        if (reset) begin
            bit_q <= '0;
            sh_q  <= '0;
        end else begin
            bit_q <= bit_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/ps2_mouse_packet_rx.sv
// ps2_mouse_packet_rx: assembles good PS/2 frames into mouse packets with
// valid/toggle handshake, sync check and a saturating error counter.
module ps2_mouse_packet_rx
    import ps2_pkg::*;
#(
    parameter int FRAME_BITS   = PS2_FRAME_BITS,
    parameter int PACKET_BYTES = 3,
    parameter int ERR_CNT_W    = 8
) (
    input  logic                      reset,
    input  logic                      ps2_clk,
    input  logic                      data_in,
    output logic [8*PACKET_BYTES-1:0] packet,
    output logic                      packet_valid,
    output logic                      packet_toggle,
    output logic                      frame_error,
    output logic                      sync_error,
    output logic [ERR_CNT_W-1:0]      err_count
);

    localparam int IW = $clog2(PACKET_BYTES);
    localparam int PW = 8 * PACKET_BYTES;

    logic [7:0]           byte_data;
    logic                 byte_done, byte_err;
    logic                 good, sync_bad, take, last;
    logic [IW-1:0]        idx_q, idx_d;
    logic [PW-1:0]        buf_q, buf_d, pkt_q, pkt_d;
    logic                 valid_q, valid_d, tog_q, tog_d, ferr_q, ferr_d, serr_q, serr_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

    ps2_frame_rx #(.FRAME_BITS(FRAME_BITS)) u_frame (
        .ps2_clk   (ps2_clk),
        .reset     (reset),
        .data_in   (data_in),
        .byte_data (byte_data),
        .byte_done (byte_done),
        .byte_err  (byte_err)
    );

    always_comb begin
        good     = byte_done && !byte_err;
        sync_bad = good && idx_q == '0 && !byte_data[PS2_SYNC_BIT];
        take     = good && !sync_bad;
        last     = take && idx_q == IW'(PACKET_BYTES - 1);
        // Any error or completed packet restarts assembly at byte 0.
        idx_d    = !byte_done ? idx_q : (take && !last) ? idx_q + 1'b1 : '0;
        buf_d    = buf_q;
        if (take)
            buf_d[idx_q*8 +: 8] = byte_data;
        pkt_d    = last ? buf_d : pkt_q;
        valid_d  = last;
        tog_d    = tog_q ^ last;
        ferr_d   = byte_done && byte_err;
        serr_d   = sync_bad;
        cnt_d    = ((ferr_d || serr_d) && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(negedge ps2_clk or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            buf_q   <= '0;
            pkt_q   <= '0;
            valid_q <= 1'b0;
            tog_q   <= 1'b0;
            ferr_q  <= 1'b0;
            serr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            pkt_q   <= pkt_d;
            valid_q <= valid_d;
            tog_q   <= tog_d;
            ferr_q  <= ferr_d;
            serr_q  <= serr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign packet        = pkt_q;
    assign packet_valid  = valid_q;
    assign packet_toggle = tog_q;
    assign frame_error   = ferr_q;
    assign sync_error    = serr_q;
    assign err_count     = cnt_q;

endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// tb_ps2_mouse_packet_rx: directed and random PS/2 frames checked against a
// frame-level reference model; a second instance covers counter saturation.
module tb_ps2_mouse_packet_rx;
    import ps2_pkg::*;

    logic        ps2_clk = 1'b1;
    logic        reset = 1'b1;
    logic        data_in = 1'b1;
    logic [23:0] packet, packet2;
    logic        packet_valid, packet_toggle, frame_error, sync_error;
    logic        packet_valid2, packet_toggle2, frame_error2, sync_error2;
    logic [7:0]  err_count;
    logic [1:0]  err_count2;

    int tests = 0;
    int fails = 0;

    logic        fq[$];
    logic [7:0]  pb[$];
    ps2_packet_t m_packet;
    logic        m_valid, m_toggle, m_ferr, m_serr;
    int          m_cnt, m_cnt2;

    always #10 ps2_clk = ~ps2_clk;

    ps2_mouse_packet_rx dut (
        .reset(reset), .ps2_clk(ps2_clk), .data_in(data_in),
        .packet(packet), .packet_valid(packet_valid), .packet_toggle(packet_toggle),
        .frame_error(frame_error), .sync_error(sync_error), .err_count(err_count)
    );

    ps2_mouse_packet_rx #(.ERR_CNT_W(2)) dut2 (
        .reset(reset), .ps2_clk(ps2_clk), .data_in(data_in),
        .packet(packet2), .packet_valid(packet_valid2), .packet_toggle(packet_toggle2),
        .frame_error(frame_error2), .sync_error(sync_error2), .err_count(err_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        pb.delete();
        m_packet = '0;
        {m_valid, m_toggle, m_ferr, m_serr} = '0;
        m_cnt = 0;
        m_cnt2 = 0;
    endtask

    task automatic model_bit(input logic b);
        logic [7:0] d;
        logic       ok;
        {m_valid, m_ferr, m_serr} = '0;
        if (fq.size() == 0 && b == 1'b1) return;
        fq.push_back(b);
        if (fq.size() == 11) begin
            for (int i = 0; i < 8; i++) d[i] = fq[i+1];
            ok = ($countones({d, fq[9]}) % 2 == 1) && fq[10] == 1'b1;
            fq.delete();
            if (!ok) begin
                m_ferr = 1'b1;
                pb.delete();
            end else if (pb.size() == 0 && !d[3]) begin
                m_serr = 1'b1;
            end else begin
                pb.push_back(d);
                if (pb.size() == 3) begin
                    m_packet = {pb[2], pb[1], pb[0]};
                    m_valid = 1'b1;
                    m_toggle = ~m_toggle;
                    pb.delete();
                end
            end
            if (m_ferr || m_serr) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
    endtask

    task automatic check_all();
        chk("packet", packet, m_packet);
        chk("valid", packet_valid, m_valid);
        chk("toggle", packet_toggle, m_toggle);
        chk("frame_error", frame_error, m_ferr);
        chk("sync_error", sync_error, m_serr);
        chk("err_count", err_count, m_cnt);
        chk("err_count_w2", err_count2, m_cnt2);
    endtask

    task automatic send_bit(input logic b);
        @(posedge ps2_clk);
        data_in = b;
        @(negedge ps2_clk);
        #1;
        model_bit(b);
        check_all();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(~^d ^ par_flip);
        send_bit(stop);
    endtask

    task automatic do_reset();
        @(posedge ps2_clk);
        #1;
        data_in = 1'b1;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        #2;
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge ps2_clk);
        #1;
        check_all();
        @(posedge ps2_clk);
        #2;
        reset = 1'b0;

        // good packet
        send_frame(8'h08, 0, 1);
        send_frame(8'h05, 0, 1);
        send_frame(8'hFB, 0, 1);
        chk("good_packet", packet, 24'hFB0508);
        chk("good_valid", packet_valid, 1'b1);
        chk("good_toggle", packet_toggle, 1'b1);
        chk("good_errcnt", err_count, 8'd0);

        // parity error on byte1, then a clean packet
        send_frame(8'h08, 0, 1);
        send_frame(8'h05, 1, 1);
        chk("par_ferr", frame_error, 1'b1);
        chk("par_errcnt", err_count, 8'd1);
        chk("par_packet_held", packet, 24'hFB0508);
        send_frame(8'h18, 0, 1);
        send_frame(8'h22, 0, 1);
        send_frame(8'h33, 0, 1);
        chk("par_next_packet", packet, 24'h332218);

        // resync
        send_frame(8'h05, 0, 1);
        chk("sync_err", sync_error, 1'b1);
        send_frame(8'h08, 0, 1);
        send_frame(8'h05, 0, 1);
        send_frame(8'hFB, 0, 1);
        chk("resync_packet", packet, 24'hFB0508);

        // start glitch
        repeat (3) send_bit(1'b1);
        send_frame(8'h09, 0, 1);
        send_frame(8'hA5, 0, 1);
        send_frame(8'h5A, 0, 1);
        chk("glitch_packet", packet, 24'h5AA509);
        chk("glitch_errcnt", err_count, 8'd2);

        // reset mid-packet
        send_frame(8'h08, 0, 1);
        send_bit(1'b0);
        repeat (3) send_bit(1'b1);
        do_reset();
        chk("rst_packet", packet, 24'h0);
        chk("rst_toggle", packet_toggle, 1'b0);
        send_frame(8'h2C, 0, 1);
        send_frame(8'h11, 0, 1);
        send_frame(8'h77, 0, 1);
        chk("rst_new_packet", packet, 24'h77112C);
        chk("rst_new_toggle", packet_toggle, 1'b1);

        // saturation on the 2-bit counter
        do_reset();
        repeat (5) send_frame(8'h08, 0, 0);
        chk("sat_w2", err_count2, 2'd3);
        chk("sat_w8", err_count, 8'd5);

        // random frames with glitches and injected errors
        for (int n = 0; n < 60; n++) begin
            logic [7:0] d;
            repeat ($urandom_range(0, 2)) send_bit(1'b1);
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) d[3] = 1'b1;
            send_frame(d, $urandom_range(0, 9) == 0, $urandom_range(0, 9) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_packet_rx.md
# ps2_mouse_packet_rx

Front-end receive stage of the PS/2 mouse path. Deserializes 11-bit device-to-host frames on `data_in`, checks start, parity and stop bits, and assembles three good bytes into one 24-bit mouse packet with a valid pulse and a CDC-safe toggle. Sits between the PS/2 pins and the paddle decoder in the 25 MHz domain, which reads the assembled packet instead of a raw 33-bit shift register.

## Interface
- `FRAME_BITS`, default 11: bits per PS/2 frame (start, 8 data, odd parity, stop).
- `PACKET_BYTES`, default 3: bytes per mouse packet.
- `ERR_CNT_W`, default 8: width of the saturating error counter.

Ports:
- `reset` in 1: asynchronous, active-high.
- `ps2_clk` in 1: PS/2 device clock; all state updates on its falling edge.
- `data_in` in 1: PS/2 data line, already synchronised to pin level.
- `packet` out 24: last good packet; byte0 in [7:0], byte1 in [15:8], byte2 in [23:16].
- `packet_valid` out 1: high from the edge a packet completes until the next falling edge.
- `packet_toggle` out 1: inverts once per good packet; used by the downstream CDC.
- `frame_error` out 1: start/stop/parity fault on the frame just closed; same duration as `packet_valid`.
- `sync_error` out 1: byte0 candidate rejected because data bit 3 = 0.
- `err_count` out ERR_CNT_W: saturating count of frame and sync errors.

## Operation
- Reset: every output is 0, bit index 0, byte index 0, shift register cleared. Reset in the middle of a frame or packet discards all partial data.
- Bit index 0 (start): sample 0 → advance to index 1. Sample 1 → stay at index 0. This is glitch tolerance, not an error.
- Indices 1–8: data bits, LSB first. Index 9: parity. Index 10: stop.
- At the stop edge:
  - Frame is good if parity makes the 9-bit total odd and stop = 1.
  - Bad frame: `frame_error` = 1, `err_count` +1, byte index → 0, partial packet discarded.
  - Good frame at byte index 0 with data bit 3 = 0: `sync_error` = 1, `err_count` +1, byte index stays 0.
  - Otherwise the byte is stored at the current index and the index advances.
  - Good byte at index PACKET_BYTES-1: `packet` is loaded with all three bytes, `packet_valid` = 1, `packet_toggle` flips, byte index → 0.
- Bit index always returns to 0 after index 10, whatever the verdict.
- `packet` holds its value until the next good packet. Errors never alter it.
- `err_count` saturates at all-ones. Sync and frame errors cannot both occur on the same edge.
- Pulse flags clear on the next falling edge that does not re-assert them. Because `ps2_clk` idles high, these pulses can last arbitrarily long. The 25 MHz consumer must edge-detect `packet_toggle`, never `packet_valid`.

## Timing
- One ps2_clk falling edge per bit; 11 edges per frame; 33 edges per packet.
- Latency: `packet`, `packet_valid` and `packet_toggle` update on the same falling edge that samples byte2's stop bit. The internal path is registered and has no added cycle.
- `packet` is stable for at least 33 ps2_clk edges after a toggle, so the consumer may double-flop the toggle and then sample `packet` directly.
- Asynchronous reset assertion clears outputs immediately. Deassertion must meet recovery time to the `ps2_clk` falling edge.

## Structure
- Package `ps2_pkg`:
  - Constants `PS2_FRAME_BITS = 11`, `PS2_START_VAL = 0`, `PS2_STOP_VAL = 1`, `PS2_SYNC_BIT = 3`.
  - Function `odd_parity_ok(data[7:0], par)`.
  - Typedef for the 24-bit packet, with byte fields.
- Sub-module `ps2_frame_rx`:
  - 11-bit deserializer with bit counter and parity/stop check.
  - Emits `byte_data[7:0]`, `byte_done` and `byte_err` at the stop edge.
- The top level holds the packet assembler: byte index 0..2, sync check, packet/flag/counter registers.

## Test plan
- **Good packet:** send frames 0x08 (parity 0), 0x05 (parity 1), 0xFB (parity 0) → after the 33rd edge, `packet` = 0xFB0508, `packet_valid` = 1, `packet_toggle` 0→1, `err_count` = 0.
- **Parity error:** byte1 0x05 sent with parity 0 → `frame_error` = 1 at its stop edge, `err_count` = 1, `packet` unchanged. A following good 3-byte packet is accepted normally.
- **Resync:** first frame 0x05 (bit 3 = 0) → `sync_error` = 1, then 0x08, 0x05, 0xFB → `packet` = 0xFB0508.
- **Start glitch:** three edges with `data_in` = 1 before a start bit → no error, and the following packet is decoded correctly.
- **Reset mid-packet:** reset asserted after byte0 and 4 bits of byte1 → all outputs 0. A new full packet then decodes correctly, with `packet_toggle` 0→1.
- **Saturation:** ERR_CNT_W = 2, five bad-stop frames → `err_count` = 3 and holds.
